// File: rtl/score_bcd_counter.sv
// score_bcd_counter
//   Score keeper for Dino Run. Qualifying distance ticks go through a prescaler.
//   Each prescaler wrap adds 1 to a packed BCD score, and the score stops at all
//   9s. A game_over pulse copies the score into the session high score when the
//   score is greater. disp_o is a registered copy of either the score or the high
//   score, and each of its nibbles drives one 7-segment decoder.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset; clears all state, including high
//   clear_i      synchronous clear of score, prescaler and new_high (new game)
//   run_i        game active; inc_i is ignored while low
//   inc_i        one-cycle distance tick
//   game_over_i  one-cycle pulse; commits the score to high if the score is greater
//   show_high_i  1: disp_o follows the high score, 0: disp_o follows the live score
//   score_o      live score, packed BCD, digit0 in [3:0]
//   high_o       high score, packed BCD
//   disp_o       display value, one cycle behind the selected register
//   new_high_o   the last game_over raised the high score
//   saturated_o  the score is all 9s
//
// Control priority on each edge: clear_i, then game_over_i, then the tick.
// When game_over_i is high, inc_i in the same cycle is dropped.

module score_bcd_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    run_i,
  input  logic                    inc_i,
  input  logic                    game_over_i,
  input  logic                    show_high_i,
  output logic [4*NUM_DIGITS-1:0] score_o,
  output logic [4*NUM_DIGITS-1:0] high_o,
  output logic [4*NUM_DIGITS-1:0] disp_o,
  output logic                    new_high_o,
  output logic                    saturated_o
);

  localparam int W    = 4 * NUM_DIGITS;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [W-1:0]    score_q;
  logic [W-1:0]    high_q;
  logic [W-1:0]    disp_q;
  logic [PS_W-1:0] pre_q;
  logic            new_high_q;

  logic [W-1:0]    score_inc;
  logic            all_nines;
  logic            tick;
  logic            pre_wrap;
  logic            score_gt_high;
  logic            carry;

  assign tick     = inc_i & run_i & ~clear_i & ~game_over_i;
  assign pre_wrap = (pre_q == PS_MAX);

  // Every digit is 0..9, so comparing the packed vectors as unsigned binary
  // gives the same result as comparing digit by digit from the MSD.
  assign score_gt_high = (score_q > high_q);

  // Ripple BCD increment. A digit at 9 becomes 0 and passes the carry on.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      score_q    <= '0;
      high_q     <= '0;
      disp_q     <= '0;
      pre_q      <= '0;
      new_high_q <= 1'b0;
    end else begin
      // The display samples the registered values, so it trails them by one cycle.
      disp_q <= show_high_i ? high_q : score_q;

      if (clear_i) begin
        score_q    <= '0;
        pre_q      <= '0;
        new_high_q <= 1'b0;
      end else if (game_over_i) begin
        if (score_gt_high) begin
          high_q     <= score_q;
          new_high_q <= 1'b1;
        end else begin
          new_high_q <= 1'b0;
        end
      end else if (tick) begin
        if (pre_wrap) begin
          pre_q <= '0;
          // At all 9s the score holds, but the prescaler keeps cycling.
          if (!all_nines) score_q <= score_inc;
        end else begin
          pre_q <= pre_q + PS_W'(1);
        end
      end
    end
  end

  assign score_o     = score_q;
  assign high_o      = high_q;
  assign disp_o      = disp_q;
  assign new_high_o  = new_high_q;
  assign saturated_o = all_nines;

endmodule

// File: tb/tb_score_bcd_counter.sv
// tb_score_bcd_counter
//   Directed and random stimulus for score_bcd_counter. The reference model
//   keeps the score as a plain decimal integer and converts it to BCD only for
//   comparison. A second instance (2 digits, prescale 1) covers saturation.

module tb_score_bcd_counter;

  localparam int PRESCALE  = 8;
  localparam int MAX_SCORE = 9999;

  logic        clk;
  logic        rst_n;
  logic        clear_i, run_i, inc_i, game_over_i, show_high_i;
  logic [15:0] score_o, high_o, disp_o;
  logic        new_high_o, saturated_o;

  logic        s_clear, s_run, s_inc, s_go, s_show;
  logic [7:0]  s_score, s_high, s_disp;
  logic        s_new_high, s_sat;

  int tests = 0;
  int fails = 0;

  // Reference model state, kept in decimal.
  int m_score, m_pre, m_high, m_disp;
  bit m_new;

  score_bcd_counter #(.NUM_DIGITS(4), .PRESCALE(PRESCALE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .run_i(run_i),
    .inc_i(inc_i), .game_over_i(game_over_i), .show_high_i(show_high_i),
    .score_o(score_o), .high_o(high_o), .disp_o(disp_o),
    .new_high_o(new_high_o), .saturated_o(saturated_o)
  );

  score_bcd_counter #(.NUM_DIGITS(2), .PRESCALE(1)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(s_clear), .run_i(s_run),
    .inc_i(s_inc), .game_over_i(s_go), .show_high_i(s_show),
    .score_o(s_score), .high_o(s_high), .disp_o(s_disp),
    .new_high_o(s_new_high), .saturated_o(s_sat)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int d;
    r = '0;
    d = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_score = 0; m_pre = 0; m_high = 0; m_disp = 0; m_new = 1'b0;
  endfunction

  // One clock edge of the reference model.
  function automatic void model_clock(input bit clr, input bit run, input bit inc,
                                      input bit go, input bit show);
    int nd;
    nd = show ? m_high : m_score;
    if (clr) begin
      m_score = 0; m_pre = 0; m_new = 1'b0;
    end else if (go) begin
      if (m_score > m_high) begin
        m_high = m_score; m_new = 1'b1;
      end else begin
        m_new = 1'b0;
      end
    end else if (inc && run) begin
      m_pre = m_pre + 1;
      if (m_pre == PRESCALE) begin
        m_pre = 0;
        if (m_score < MAX_SCORE) m_score = m_score + 1;
      end
    end
    m_disp = nd;
  endfunction

  // Scoreboard helpers
  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk16({tag, ".score"}, score_o, to_bcd(m_score));
    chk16({tag, ".high"},  high_o,  to_bcd(m_high));
    chk16({tag, ".disp"},  disp_o,  to_bcd(m_disp));
    chk1 ({tag, ".new_high"}, new_high_o, m_new);
    chk1 ({tag, ".saturated"}, saturated_o, m_score == MAX_SCORE);
  endtask

  // Driver: apply inputs on the falling edge, advance the model on the rising
  // edge, then sample 1 ns later.
  task automatic step(input bit clr, input bit run, input bit inc, input bit go,
                      input bit show, input string tag);
    @(negedge clk);
    clear_i = clr; run_i = run; inc_i = inc; game_over_i = go; show_high_i = show;
    @(posedge clk);
    model_clock(clr, run, inc, go, show);
    #1;
    check_all(tag);
  endtask

  initial begin
    clear_i = 0; run_i = 0; inc_i = 0; game_over_i = 0; show_high_i = 0;
    s_clear = 0; s_run = 0; s_inc = 0; s_go = 0; s_show = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk16("reset_score_const", score_o, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Eight inc pulses, separated by idle cycles: score moves only after the 8th.
    for (int p = 1; p <= 8; p++) begin
      step(0, 1, 1, 0, 0, "pulse");
      if (p < 8) chk16("pulse_no_change", score_o, 16'h0000);
      step(0, 1, 0, 0, 0, "pulse_idle");
    end
    chk16("score_after_8th", score_o, 16'h0001);

    // Count up through a carry across two digits.
    for (int k = 0; k < 2000 && m_score < 99; k++) step(0, 1, 1, 0, 0, "run99");
    chk16("score_0099", score_o, 16'h0099);
    repeat (8) step(0, 1, 1, 0, 0, "run100");
    chk16("score_0100", score_o, 16'h0100);
    for (int k = 0; k < 2000 && m_score < 123; k++) step(0, 1, 1, 0, 0, "run123");
    chk16("score_0123", score_o, 16'h0123);

    // A game over with score greater than high raises high; a clear keeps high.
    step(0, 1, 0, 1, 0, "go_new_high");
    chk16("go_high", high_o, 16'h0123);
    chk1 ("go_new_high_flag", new_high_o, 1'b1);
    step(1, 1, 0, 0, 0, "clear_after_go");
    chk16("clear_score", score_o, 16'h0000);
    chk16("clear_keeps_high", high_o, 16'h0123);
    chk1 ("clear_new_high", new_high_o, 1'b0);

    // A lower score leaves high unchanged; an inc in the same cycle is dropped.
    for (int k = 0; k < 1000 && m_score < 45; k++) step(0, 1, 1, 0, 0, "run45");
    repeat (7) step(0, 1, 1, 0, 0, "pre7");
    step(0, 1, 1, 1, 0, "go_low_with_inc");
    chk16("go_low_high", high_o, 16'h0123);
    chk1 ("go_low_new_high", new_high_o, 1'b0);
    chk16("go_low_score", score_o, 16'h0045);
    step(0, 1, 1, 0, 0, "after_go_tick");
    chk16("dropped_inc_then_tick", score_o, 16'h0046);

    // A clear wins over an inc in the same cycle and resets the prescaler.
    step(1, 1, 0, 0, 0, "clear2");
    for (int k = 0; k < 200 && m_score < 7; k++) step(0, 1, 1, 0, 0, "run7");
    repeat (3) step(0, 1, 1, 0, 0, "pre3");
    step(1, 1, 1, 0, 0, "clear_with_inc");
    chk16("clear_inc_score", score_o, 16'h0000);
    repeat (7) step(0, 1, 1, 0, 0, "pre_restart");
    chk16("prescaler_cleared", score_o, 16'h0000);
    step(0, 1, 1, 0, 0, "pre_restart_8");
    chk16("prescaler_8th", score_o, 16'h0001);

    // With run low, twenty incs leave the score frozen.
    repeat (20) step(0, 0, 1, 0, 0, "frozen");
    chk16("frozen_score", score_o, 16'h0001);

    // Display select: disp follows high one cycle after show_high goes high.
    step(0, 1, 0, 0, 0, "show_score");
    chk16("disp_is_score", disp_o, 16'h0001);
    @(negedge clk);
    show_high_i = 1'b1;
    #1;
    chk16("disp_lags_select", disp_o, 16'h0001);
    step(0, 1, 0, 0, 1, "show_high");
    chk16("disp_is_high", disp_o, 16'h0123);

    // Random phase, checked against the model every cycle.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1, "random");
    end

    // Saturation on the 2-digit, prescale-1 instance.
    @(negedge clk);
    clear_i = 0; run_i = 0; inc_i = 0; game_over_i = 0; show_high_i = 0;
    s_clear = 1'b1;
    @(negedge clk);
    s_clear = 1'b0;
    s_run = 1'b1;
    for (int k = 1; k <= 105; k++) begin
      s_inc = 1'b1;
      @(posedge clk);
      #1;
      chk16("sat_score", {8'h00, s_score}, to_bcd(k > 99 ? 99 : k));
      chk1 ("sat_flag", s_sat, k >= 99);
      @(negedge clk);
    end
    s_inc = 1'b0;
    chk16("sat_hold_9999_style", {8'h00, s_score}, 16'h0099);
    chk1 ("sat_flag_hold", s_sat, 1'b1);

    // Resync the main model: inputs were idle apart from the display select,
    // so only the display register changed.
    @(posedge clk);
    model_clock(0, 0, 0, 0, 0);
    #1;
    check_all("resync");

    // Asynchronous reset in the middle of counting.
    for (int k = 0; k < 30; k++) step(0, 1, 1, 0, k[0], "precount");
    step(0, 1, 1, 1, 1, "precount_go");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    chk16("async_reset_high", high_o, 16'h0000);
    chk16("async_reset_sat", {8'h00, s_score}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) step(0, 1, 1, 0, 0, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
